// File: rtl/div_digit_pkg.sv
// Shared types and elaboration-time helpers for the radix digit serializer.
// Holds the FSM state encoding, parameter legality rule and digit-count bound.
package div_digit_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int RADIX_MIN = 2;
    localparam int RADIX_MAX = 16;

    // A digit must fit in digit_w bits and the base must stay within 2..16.
    function automatic bit radix_legal(input int radix, input int digit_w);
        return (radix >= RADIX_MIN) && (radix <= RADIX_MAX) &&
               ((longint'(1) << digit_w) >= longint'(radix));
    endfunction

    // Smallest n with radix**n >= 2**width, i.e. ceil(width*log(2)/log(radix)).
    function automatic int max_digits(input int width, input int radix);
        longint limit;
        longint power;
        int     count;
        limit = longint'(1) << width;
        power = 1;
        count = 0;
        if (radix < RADIX_MIN) begin
            return width;
        end
        while (power < limit) begin
            power = power * longint'(radix);
            count = count + 1;
        end
        return count;
    endfunction

endpackage

// File: rtl/div_by_const.sv
// Combinational unsigned quotient and remainder of a width-bit value by a constant radix.
// The remainder is always below radix, so it is narrowed to the digit width.
module div_by_const
    import div_digit_pkg::*;
#(
    parameter int width   = 8,
    parameter int radix   = 10,
    parameter int digit_w = 4
) (
    input  logic [width-1:0]   value,
    output logic [width-1:0]   quotient,
    output logic [digit_w-1:0] remainder
);

    localparam logic [width-1:0] DIVISOR = width'(radix);

    assign quotient  = value / DIVISOR;
    assign remainder = digit_w'(value % DIVISOR);

endmodule

// File: rtl/div_digit_serializer.sv
// Converts one signed or unsigned integer into base-radix digits, least significant first,
// emitting one digit per valid/ready handshake from a shrinking working register.
module div_digit_serializer
    import div_digit_pkg::*;
#(
    parameter int width   = 8,
    parameter int radix   = 10,
    parameter int digit_w = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width-1:0]   in_value,
    input  logic               in_tc,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [digit_w-1:0] out_digit,
    output logic [width-1:0]   out_idx,
    output logic               out_last,
    output logic               out_neg
);

    localparam int               MAX_DIGITS = max_digits(width, radix);
    localparam logic [width-1:0] ONE        = width'(1);

    generate
        if (!radix_legal(radix, digit_w)) begin : g_bad_params
            $error("div_digit_serializer: radix must be 2..16 and fit in digit_w bits");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [width-1:0]   work_q, work_d;
    logic [width-1:0]   idx_q, idx_d;
    logic               neg_q, neg_d;
    logic [width-1:0]   quot;
    logic [digit_w-1:0] digit;
    logic [width-1:0]   magnitude;
    logic               is_last;

    div_by_const #(
        .width   (width),
        .radix   (radix),
        .digit_w (digit_w)
    ) u_div (
        .value     (work_q),
        .quotient  (quot),
        .remainder (digit)
    );

    // The most negative value negates to 2**(width-1), which still fits unsigned.
    assign magnitude = (in_tc && in_value[width-1]) ? (~in_value + ONE) : in_value;
    assign is_last   = (quot == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            idx_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        idx_d     = idx_q;
        neg_d     = neg_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_digit = digit;
        out_idx   = idx_q;
        out_last  = is_last;
        out_neg   = neg_q;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = magnitude;
                    neg_d   = in_tc & in_value[width-1];
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    work_d = quot;
                    idx_d  = idx_q + ONE;
                    if (is_last) begin
                        state_d = IDLE;
                    end
                end
                // A digit transferred alongside abort still counts as delivered.
                if (abort) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assert property (@(posedge clk) disable iff (!rst_n)
                     out_valid |-> (32'(out_idx) < MAX_DIGITS));

endmodule

// File: tb/tb_div_digit_serializer.sv
// Directed self-checking bench for div_digit_serializer in radix 10 and radix 16.
// Each task drives one scenario and compares observed outputs against hand-computed digits.
module tb_div_digit_serializer;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, in_tc, abort, out_valid, out_ready, out_last, out_neg;
    logic [7:0] in_value, out_idx;
    logic [3:0] out_digit;

    logic       in_valid_h, in_ready_h, in_tc_h, abort_h, out_valid_h, out_ready_h;
    logic       out_last_h, out_neg_h;
    logic [7:0] in_value_h, out_idx_h;
    logic [3:0] out_digit_h;

    int tests;
    int failed;

    div_digit_serializer #(.width(8), .radix(10), .digit_w(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_tc     (in_tc),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_neg   (out_neg)
    );

    div_digit_serializer #(.width(8), .radix(16), .digit_w(4)) dut_hex (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_h),
        .in_ready  (in_ready_h),
        .in_value  (in_value_h),
        .in_tc     (in_tc_h),
        .abort     (abort_h),
        .out_valid (out_valid_h),
        .out_ready (out_ready_h),
        .out_digit (out_digit_h),
        .out_idx   (out_idx_h),
        .out_last  (out_last_h),
        .out_neg   (out_neg_h)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_value = 8'd0; in_tc = 1'b0; abort = 1'b0; out_ready = 1'b0;
        in_valid_h = 1'b0; in_value_h = 8'd0; in_tc_h = 1'b0; abort_h = 1'b0; out_ready_h = 1'b0;
        #3;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_digit !== 4'd0 || out_idx !== 8'd0 ||
            out_last !== 1'b1 || out_neg !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_dec: ready=%b valid=%b digit=%0d idx=%0d last=%b neg=%b, expected 1 0 0 0 1 0",
                     in_ready, out_valid, out_digit, out_idx, out_last, out_neg);
        end
        tests++;
        if (in_ready_h !== 1'b1 || out_valid_h !== 1'b0 || out_digit_h !== 4'd0 || out_idx_h !== 8'd0 ||
            out_last_h !== 1'b1 || out_neg_h !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_hex: ready=%b valid=%b digit=%0d idx=%0d last=%b neg=%b, expected 1 0 0 0 1 0",
                     in_ready_h, out_valid_h, out_digit_h, out_idx_h, out_last_h, out_neg_h);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] exp_d [3];
        exp_d = '{4'd3, 4'd2, 4'd1};
        @(negedge clk);
        in_valid = 1'b1; in_value = 8'd123; in_tc = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        // Changing the inputs after acceptance must not disturb the digits.
        in_valid = 1'b0; in_value = 8'd99; in_tc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_digit !== exp_d[i] || out_idx !== 8'(i) ||
                out_last !== (i == 2) || out_neg !== 1'b0 || in_ready !== 1'b0) begin
                failed++;
                $display("[TB] FAIL basic_123 digit %0d: valid=%b digit=%0d idx=%0d last=%b neg=%b ready=%b, expected 1 %0d %0d %b 0 0",
                         i, out_valid, out_digit, out_idx, out_last, out_neg, in_ready, exp_d[i], i, (i == 2));
            end
            @(negedge clk);
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL basic_idle: ready=%b valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        in_valid = 1'b1; in_value = 8'd0; in_tc = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_digit !== 4'd0 || out_idx !== 8'd0 || out_last !== 1'b1 || out_neg !== 1'b0) begin
            failed++;
            $display("[TB] FAIL zero: valid=%b digit=%0d idx=%0d last=%b neg=%b, expected 1 0 0 1 0",
                     out_valid, out_digit, out_idx, out_last, out_neg);
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL zero_idle: ready=%b valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    // Requests are issued back to back, each at the first cycle in_ready is seen high.
    task automatic test_signed();
        logic [7:0] vals  [3];
        logic       tcs   [3];
        int         cnt   [3];
        logic       negs  [3];
        logic [3:0] digs  [3][3];
        vals = '{8'hFF, 8'hFF, 8'h80};
        tcs  = '{1'b1, 1'b0, 1'b1};
        cnt  = '{1, 3, 3};
        negs = '{1'b1, 1'b0, 1'b1};
        digs = '{'{4'd1, 4'd0, 4'd0}, '{4'd5, 4'd5, 4'd2}, '{4'd8, 4'd2, 4'd1}};
        @(negedge clk);
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1; in_value = vals[v]; in_tc = tcs[v];
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < cnt[v]; i++) begin
                tests++;
                if (out_valid !== 1'b1 || out_digit !== digs[v][i] || out_idx !== 8'(i) ||
                    out_last !== (i == cnt[v] - 1) || out_neg !== negs[v]) begin
                    failed++;
                    $display("[TB] FAIL signed %0d digit %0d: valid=%b digit=%0d idx=%0d last=%b neg=%b, expected 1 %0d %0d %b %b",
                             v, i, out_valid, out_digit, out_idx, out_last, out_neg,
                             digs[v][i], i, (i == cnt[v] - 1), negs[v]);
                end
                @(negedge clk);
            end
            tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failed++;
                $display("[TB] FAIL signed %0d idle: ready=%b valid=%b, expected 1 0", v, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp_d [3];
        logic       pat   [8];
        int         k;
        int         cyc;
        exp_d = '{4'd0, 4'd0, 4'd2};
        pat   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        k   = 0;
        cyc = 0;
        @(negedge clk);
        in_valid = 1'b1; in_value = 8'd200; in_tc = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        while (k < 3 && cyc < 24) begin
            tests++;
            if (out_valid !== 1'b1 || out_digit !== exp_d[k] || out_idx !== 8'(k) ||
                out_last !== (k == 2) || in_ready !== 1'b0) begin
                failed++;
                $display("[TB] FAIL stall cycle %0d digit %0d: valid=%b digit=%0d idx=%0d last=%b ready=%b, expected 1 %0d %0d %b 0",
                         cyc, k, out_valid, out_digit, out_idx, out_last, in_ready, exp_d[k], k, (k == 2));
            end
            out_ready = pat[cyc % 8];
            @(negedge clk);
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b1;
        tests++;
        if (k != 3 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL stall_done: digits=%0d ready=%b valid=%b, expected 3 1 0", k, in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        in_valid = 1'b1; in_value = 8'd234; in_tc = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_digit !== 4'd4 || out_idx !== 8'd0 || out_last !== 1'b0) begin
            failed++;
            $display("[TB] FAIL abort_d0: valid=%b digit=%0d idx=%0d last=%b, expected 1 4 0 0",
                     out_valid, out_digit, out_idx, out_last);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_digit !== 4'd3 || out_idx !== 8'd1 || out_last !== 1'b0) begin
            failed++;
            $display("[TB] FAIL abort_d1: valid=%b digit=%0d idx=%0d last=%b, expected 1 3 1 0",
                     out_valid, out_digit, out_idx, out_last);
        end
        abort = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL abort_idle: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
        // abort held while idle must not block a new request.
        in_valid = 1'b1; in_value = 8'd7;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_digit !== 4'd7 || out_idx !== 8'd0 || out_last !== 1'b1 || out_neg !== 1'b0) begin
            failed++;
            $display("[TB] FAIL abort_new: valid=%b digit=%0d idx=%0d last=%b neg=%b, expected 1 7 0 1 0",
                     out_valid, out_digit, out_idx, out_last, out_neg);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL abort_new_idle: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_radix16();
        @(negedge clk);
        in_valid_h = 1'b1; in_value_h = 8'hAB; in_tc_h = 1'b0; out_ready_h = 1'b1;
        @(negedge clk);
        in_valid_h = 1'b0;
        tests++;
        if (out_valid_h !== 1'b1 || out_digit_h !== 4'hB || out_idx_h !== 8'd0 || out_last_h !== 1'b0) begin
            failed++;
            $display("[TB] FAIL hex_d0: valid=%b digit=%h idx=%0d last=%b, expected 1 b 0 0",
                     out_valid_h, out_digit_h, out_idx_h, out_last_h);
        end
        @(negedge clk);
        tests++;
        if (out_valid_h !== 1'b1 || out_digit_h !== 4'hA || out_idx_h !== 8'd1 || out_last_h !== 1'b1) begin
            failed++;
            $display("[TB] FAIL hex_d1: valid=%b digit=%h idx=%0d last=%b, expected 1 a 1 1",
                     out_valid_h, out_digit_h, out_idx_h, out_last_h);
        end
        @(negedge clk);
        tests++;
        if (out_valid_h !== 1'b0 || in_ready_h !== 1'b1) begin
            failed++;
            $display("[TB] FAIL hex_idle: valid=%b ready=%b, expected 0 1", out_valid_h, in_ready_h);
        end
        in_valid_h = 1'b1; in_value_h = 8'hAB; out_ready_h = 1'b0;
        @(negedge clk);
        in_valid_h = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid_h !== 1'b1 || out_digit_h !== 4'hB || out_idx_h !== 8'd0) begin
            failed++;
            $display("[TB] FAIL hex_hold: valid=%b digit=%h idx=%0d, expected 1 b 0",
                     out_valid_h, out_digit_h, out_idx_h);
        end
        // Reset lands between clock edges, so the clear must not wait for one.
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready_h !== 1'b1 || out_valid_h !== 1'b0 || out_digit_h !== 4'd0 || out_idx_h !== 8'd0 ||
            out_last_h !== 1'b1 || out_neg_h !== 1'b0) begin
            failed++;
            $display("[TB] FAIL hex_async_reset: ready=%b valid=%b digit=%h idx=%0d last=%b neg=%b, expected 1 0 0 0 1 0",
                     in_ready_h, out_valid_h, out_digit_h, out_idx_h, out_last_h, out_neg_h);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_h = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid_h !== 1'b0 || in_ready_h !== 1'b1) begin
            failed++;
            $display("[TB] FAIL hex_post_reset: valid=%b ready=%b, expected 0 1", out_valid_h, in_ready_h);
        end
        in_valid_h = 1'b1; in_value_h = 8'h05;
        @(negedge clk);
        in_valid_h = 1'b0;
        tests++;
        if (out_valid_h !== 1'b1 || out_digit_h !== 4'h5 || out_idx_h !== 8'd0 || out_last_h !== 1'b1) begin
            failed++;
            $display("[TB] FAIL hex_five: valid=%b digit=%h idx=%0d last=%b, expected 1 5 0 1",
                     out_valid_h, out_digit_h, out_idx_h, out_last_h);
        end
        @(negedge clk);
        tests++;
        if (out_valid_h !== 1'b0 || in_ready_h !== 1'b1) begin
            failed++;
            $display("[TB] FAIL hex_five_idle: valid=%b ready=%b, expected 0 1", out_valid_h, in_ready_h);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_basic();
        test_zero();
        test_signed();
        test_stall();
        test_abort();
        test_radix16();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
